// File: rtl/picorv_pkg.sv
// Shared arbiter definitions: ownership state encoding and XLEN legality check.
package picorv_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  function automatic logic xlen_ok(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/picorv_rrarb2.sv
// 2-way round-robin next-owner selector, purely combinational.
// prio names the winner when both ports request at once.
module picorv_rrarb2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic prio_i,
  output logic win_vld_o,
  output logic win_o
);

  assign win_vld_o = req0_i | req1_i;
  assign win_o     = (req0_i && req1_i) ? prio_i : req1_i;

endmodule

// File: rtl/picorv_memarb.sv
// Two-master reqst/grant memory arbiter: registered ownership, round-robin ties,
// combinational data path so transfers add no latency.
module picorv_memarb
  import picorv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_reqst,
  output logic              p0_grant,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic [XLEN-1:0]   p0_addr,
  input  logic [XLEN-1:0]   p0_wdata,
  input  logic [XLEN/8-1:0] p0_wstrb,
  output logic [XLEN-1:0]   p0_rdata,
  input  logic              p1_reqst,
  output logic              p1_grant,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [XLEN-1:0]   p1_addr,
  input  logic [XLEN-1:0]   p1_wdata,
  input  logic [XLEN/8-1:0] p1_wstrb,
  output logic [XLEN-1:0]   p1_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic [XLEN-1:0]   mem_rdata
);

  if (!xlen_ok(XLEN)) begin : g_xlen_chk
    $error("picorv_memarb: XLEN must be 32 or 64");
  end

  arb_state_e state_q;
  logic       prio_q;
  logic       win_vld;
  logic       win;
  logic       own_reqst;
  logic       own_valid;
  logic       owner_release;

  // Raw requests suffice: a releasing owner has its own reqst low already.
  picorv_rrarb2 u_rrarb (
    .req0_i    (p0_reqst),
    .req1_i    (p1_reqst),
    .prio_i    (prio_q),
    .win_vld_o (win_vld),
    .win_o     (win)
  );

  always_comb begin
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    own_reqst = 1'b0;
    own_valid = 1'b0;
    case (state_q)
      ARB_OWN0: begin
        mem_valid = p0_valid;
        mem_addr  = p0_addr;
        mem_wdata = p0_wdata;
        mem_wstrb = p0_wstrb;
        own_reqst = p0_reqst;
        own_valid = p0_valid;
      end
      ARB_OWN1: begin
        mem_valid = p1_valid;
        mem_addr  = p1_addr;
        mem_wdata = p1_wdata;
        mem_wstrb = p1_wstrb;
        own_reqst = p1_reqst;
        own_valid = p1_valid;
      end
      default: ;
    endcase
  end

  // An owner with a transfer still in flight keeps the bus even without reqst.
  assign owner_release = (state_q != ARB_IDLE) && !own_reqst && !own_valid && !mem_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      prio_q  <= 1'b1;
    end else if (state_q == ARB_IDLE || owner_release) begin
      if (win_vld) begin
        state_q <= win ? ARB_OWN1 : ARB_OWN0;
        prio_q  <= ~win;
      end else begin
        state_q <= ARB_IDLE;
      end
    end
  end

  assign p0_grant = (state_q == ARB_OWN0);
  assign p1_grant = (state_q == ARB_OWN1);
  assign p0_ready = mem_ready && mem_valid && (state_q == ARB_OWN0);
  assign p1_ready = mem_ready && mem_valid && (state_q == ARB_OWN1);
  assign p0_rdata = mem_rdata;
  assign p1_rdata = mem_rdata;

endmodule
